food_placer: RTL and testbench
==============================

FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 SHALL have parameter GRID_W, default 40, number of valid columns (1..63).
REQ-002 SHALL have parameter GRID_H, default 30, number of valid rows (1..63).
REQ-003 SHALL have parameter MAX_TRIES, default 16, number of rejected candidates before the placement is abandoned (1..255).
REQ-004 SHALL have port clk, input, 1, single rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rnd_x, input, 6, free-running random X value from the coordinate generator.
REQ-007 SHALL have port rnd_y, input, 6, free-running random Y value from the coordinate generator.
REQ-008 SHALL have port place_req, input, 1, request for a new food position, sampled each edge.
REQ-009 SHALL have port clear, input, 1, synchronous game-restart request.
REQ-010 SHALL have port occupied_in, input, 1, snake/wall occupancy answer, valid one cycle after query_valid.
REQ-011 SHALL have port query_x, output, 6, registered candidate X presented to the occupancy lookup.
REQ-012 SHALL have port query_y, output, 6, registered candidate Y presented to the occupancy lookup.
REQ-013 SHALL have port query_valid, output, 1, one-cycle occupancy lookup strobe.
REQ-014 SHALL have port food_x, output, 6, committed food column.
REQ-015 SHALL have port food_y, output, 6, committed food row.
REQ-016 SHALL have port food_valid, output, 1, committed food position is valid.
REQ-017 SHALL have port busy, output, 1, placement in progress.
REQ-018 SHALL have port place_done, output, 1, one-cycle pulse on a successful commit.
REQ-019 SHALL have port place_fail, output, 1, one-cycle pulse when MAX_TRIES is exhausted.

Function
REQ-020 SHALL implement the FSM states IDLE, SAMPLE, QUERY and WAIT; busy SHALL be 1 in every state except IDLE.
REQ-021 In IDLE, on place_req=1: food_valid<=0, try counter<=0, next state SAMPLE.
REQ-022 In any state other than IDLE, place_req SHALL be ignored.
REQ-023 In SAMPLE, each coordinate SHALL be folded: value minus GRID (W or H) if value>=GRID, else value unchanged, using 6-bit arithmetic.
REQ-024 In SAMPLE, if both folded values are in range, they SHALL be captured into query_x/query_y and the state SHALL go to QUERY.
REQ-025 In SAMPLE, if either folded value is still >=GRID, it SHALL count as a rejection and the state SHALL stay in SAMPLE (new rnd values sampled next edge).
REQ-026 query_valid SHALL be 1 exactly in the cycle the FSM is in QUERY; the next state SHALL be WAIT.
REQ-027 In WAIT, occupied_in SHALL be sampled; if it is 0: food_x/food_y<=query_x/query_y, food_valid<=1, place_done pulse, next state IDLE.
REQ-028 In WAIT, if occupied_in is 1, it SHALL count as a rejection and the next state SHALL be SAMPLE.
REQ-029 On a rejection: if the try counter equals MAX_TRIES-1, place_fail SHALL pulse, food_valid SHALL stay 0, and the next state SHALL be IDLE; otherwise the counter SHALL increment.
REQ-030 Best-case latency SHALL be: place_req sampled at edge N, query_valid high during cycle N+1..N+2, food_valid and place_done high after edge N+3.
REQ-031 clear=1 SHALL override all other inputs: state<=IDLE, food_valid<=0, query_valid<=0, counter<=0, no done/fail pulse; food_x/food_y SHALL hold.
REQ-032 clear and place_req high on the same edge: clear SHALL win and the request SHALL be dropped.
REQ-033 food_x/food_y SHALL change only on a commit or on reset.

Reset
REQ-034 While rst_n=0, outputs SHALL asynchronously go to: state IDLE, counter 0, query_x/query_y 0, query_valid 0, food_x/food_y 0, food_valid 0, busy 0, place_done 0, place_fail 0.
REQ-035 Reset asserted mid-placement SHALL abandon the placement with no done/fail pulse; after release, the block SHALL wait for a new place_req.

Verification
REQ-036 Bench: rnd=(5,7), occupied_in=0, place_req pulse at edge N -> query (5,7) during N+1, food=(5,7), food_valid=1 and place_done=1 after edge N+3.
REQ-037 Bench: rnd=(45,33), occupied_in=0 -> query (5,3), food=(5,3).
REQ-038 Bench: rnd_y=63 (folds to 33) for 3 cycles, then rnd=(10,10) -> 3 rejections, then query (10,10), commit after edge N+6.
REQ-039 Bench: occupied_in held 1 -> 16 queries, place_fail one-cycle pulse, food_valid=0, busy=0, no place_done.
REQ-040 Bench: occupied_in=1 for the first 2 queries then 0 -> food equals the third candidate and the try counter resets on the next place_req.
REQ-041 Bench: clear during WAIT and rst_n low during QUERY -> IDLE, food_valid=0, no pulses; later place_req places normally.

Source files
------------

// File: rtl/food_placer.sv
// Food placement: draws random grid coordinates, folds them into range,
// asks the occupancy lookup, and commits the first free cell found.
module food_placer #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] rnd_x,
    input  logic [5:0] rnd_y,
    input  logic       place_req,
    input  logic       clear,
    input  logic       occupied_in,
    output logic [5:0] query_x,
    output logic [5:0] query_y,
    output logic       query_valid,
    output logic [5:0] food_x,
    output logic [5:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       place_done,
    output logic       place_fail
);

    localparam logic [5:0] GW   = 6'(GRID_W);
    localparam logic [5:0] GH   = 6'(GRID_H);
    localparam logic [7:0] LAST = 8'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, QUERY, WAIT} state_t;

    state_t     r_state, w_state_nx;
    logic [7:0] r_tries, w_tries_nx;
    logic [5:0] r_qx, w_qx_nx;
    logic [5:0] r_qy, w_qy_nx;
    logic [5:0] r_fx, w_fx_nx;
    logic [5:0] r_fy, w_fy_nx;
    logic       r_fvalid, w_fvalid_nx;
    logic       r_done, w_done_nx;
    logic       r_fail, w_fail_nx;
    logic       w_rej;

    logic [5:0] w_fold_x;
    logic [5:0] w_fold_y;
    logic       w_in_range;

    // single subtraction only: raw values far above the grid stay out of range
    assign w_fold_x   = (rnd_x >= GW) ? rnd_x - GW : rnd_x;
    assign w_fold_y   = (rnd_y >= GH) ? rnd_y - GH : rnd_y;
    assign w_in_range = (w_fold_x < GW) && (w_fold_y < GH);

    always_comb begin
        w_state_nx  = r_state;
        w_tries_nx  = r_tries;
        w_qx_nx     = r_qx;
        w_qy_nx     = r_qy;
        w_fx_nx     = r_fx;
        w_fy_nx     = r_fy;
        w_fvalid_nx = r_fvalid;
        w_done_nx   = 1'b0;
        w_fail_nx   = 1'b0;
        w_rej       = 1'b0;
        if (clear) begin
            w_state_nx  = IDLE;
            w_tries_nx  = 8'd0;
            w_fvalid_nx = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (place_req) begin
                        w_fvalid_nx = 1'b0;
                        w_tries_nx  = 8'd0;
                        w_state_nx  = SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (w_in_range) begin
                        w_qx_nx    = w_fold_x;
                        w_qy_nx    = w_fold_y;
                        w_state_nx = QUERY;
                    end else begin
                        w_rej = 1'b1;
                    end
                end
                QUERY: w_state_nx = WAIT;
                WAIT: begin
                    if (!occupied_in) begin
                        w_fx_nx     = r_qx;
                        w_fy_nx     = r_qy;
                        w_fvalid_nx = 1'b1;
                        w_done_nx   = 1'b1;
                        w_state_nx  = IDLE;
                    end else begin
                        w_rej = 1'b1;
                    end
                end
            endcase
            if (w_rej) begin
                if (r_tries == LAST) begin
                    w_fail_nx  = 1'b1;
                    w_state_nx = IDLE;
                end else begin
                    w_tries_nx = r_tries + 8'd1;
                    w_state_nx = SAMPLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tries  <= 8'd0;
            r_qx     <= 6'd0;
            r_qy     <= 6'd0;
            r_fx     <= 6'd0;
            r_fy     <= 6'd0;
            r_fvalid <= 1'b0;
            r_done   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_tries  <= w_tries_nx;
            r_qx     <= w_qx_nx;
            r_qy     <= w_qy_nx;
            r_fx     <= w_fx_nx;
            r_fy     <= w_fy_nx;
            r_fvalid <= w_fvalid_nx;
            r_done   <= w_done_nx;
            r_fail   <= w_fail_nx;
        end
    end

    assign query_x     = r_qx;
    assign query_y     = r_qy;
    assign query_valid = (r_state == QUERY);
    assign food_x      = r_fx;
    assign food_y      = r_fy;
    assign food_valid  = r_fvalid;
    assign busy        = (r_state != IDLE);
    assign place_done  = r_done;
    assign place_fail  = r_fail;

endmodule

// File: tb/tb_food_placer.sv
// Randomized scoreboard bench for food_placer: a draw-level model predicts
// every query, commit and failure together with its edge offset.
module tb_food_placer;

    localparam int W  = 40;
    localparam int H  = 30;
    localparam int MT = 16;

    logic       clk = 0;
    logic       rst_n = 0;
    logic [5:0] rnd_x = 0, rnd_y = 0;
    logic       place_req = 0, clear = 0, occupied_in = 0;
    logic [5:0] query_x, query_y, food_x, food_y;
    logic       query_valid, food_valid, busy, place_done, place_fail;

    food_placer #(.GRID_W(W), .GRID_H(H), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst_n(rst_n), .rnd_x(rnd_x), .rnd_y(rnd_y),
        .place_req(place_req), .clear(clear), .occupied_in(occupied_in),
        .query_x(query_x), .query_y(query_y), .query_valid(query_valid),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .place_done(place_done), .place_fail(place_fail)
    );

    always #5 clk = ~clk;

    typedef struct {int kind; int k; int x; int y;} ev_t;
    ev_t sb[$];

    int total = 0, bad = 0;
    int cyc = 0, base = 0, qidx = 0;
    int rx[64], ry[64];
    bit occ[16];
    int m_fx = 0, m_fy = 0;
    bit m_fv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Occupancy lookup: answers each query from the prepared table.
    always @(negedge clk) begin
        if (rst_n && query_valid) begin
            occupied_in = (qidx < 16) ? occ[qidx] : 1'b1;
            qidx++;
        end
    end

    task automatic observe(int kind, int x, int y);
        ev_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected event kind=%0d at k=%0d", kind, cyc - base);
        end else begin
            e = sb.pop_front();
            chk("event kind", kind, e.kind);
            chk("event edge", cyc - base, e.k);
            chk("event x", x, e.x);
            chk("event y", y, e.y);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (query_valid) observe(0, query_x, query_y);
            if (place_done) begin
                observe(1, food_x, food_y);
                chk("valid at done", food_valid, 1);
            end
            if (place_fail) observe(2, food_x, food_y);
        end
    end

    // Draw-level model: rx/ry[k] is the raw pair seen at edge N+k.
    function automatic int model_txn();
        int k = 1, tries = 0, q = 0, xi, yi;
        m_fv = 0;
        while (1) begin
            xi = rx[k];
            yi = ry[k];
            if (xi >= W) xi -= W;
            if (yi >= H) yi -= H;
            if (xi < W && yi < H) begin
                sb.push_back('{0, k, xi, yi});
                if (!occ[q]) begin
                    sb.push_back('{1, k + 2, xi, yi});
                    m_fx = xi;
                    m_fy = yi;
                    m_fv = 1;
                    return k + 2;
                end
                q++;
                k += 2;
            end
            if (tries == MT - 1) begin
                sb.push_back('{2, k, m_fx, m_fy});
                return k;
            end
            tries++;
            k++;
        end
        return k;
    endfunction

    task automatic post_check(string tag);
        chk({tag, " queue empty"}, sb.size(), 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " food_valid"}, food_valid, m_fv);
        chk({tag, " food_x"}, food_x, m_fx);
        chk({tag, " food_y"}, food_y, m_fy);
    endtask

    task automatic run_txn(string tag);
        int end_k;
        qidx = 0;
        end_k = model_txn();
        @(posedge clk); #1;
        place_req = 1;
        rnd_x = 6'(rx[0]);
        rnd_y = 6'(ry[0]);
        @(posedge clk); #1;
        base = cyc;
        place_req = 0;
        rnd_x = 6'(rx[1]);
        rnd_y = 6'(ry[1]);
        for (int k = 1; k < end_k + 3; k++) begin
            @(posedge clk); #1;
            if (k + 1 < 64) begin
                rnd_x = 6'(rx[k + 1]);
                rnd_y = 6'(ry[k + 1]);
            end
        end
        post_check(tag);
    endtask

    task automatic fill(int x, int y, bit o);
        for (int i = 0; i < 64; i++) begin
            rx[i] = x;
            ry[i] = y;
        end
        for (int i = 0; i < 16; i++) occ[i] = o;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            rx[i] = $urandom_range(0, 63);
            ry[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(56, 63)
                                                : $urandom_range(0, 63);
        end
        for (int i = 0; i < 16; i++) occ[i] = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        #3;
        chk("rst busy", busy, 0);
        chk("rst food_valid", food_valid, 0);
        chk("rst query_valid", query_valid, 0);
        chk("rst food_x", food_x, 0);
        chk("rst done|fail", place_done | place_fail, 0);
        #20;
        @(posedge clk); #1;
        rst_n = 1;

        fill(5, 7, 0);
        run_txn("basic");
        fill(45, 33, 0);
        run_txn("fold");
        fill(10, 10, 0);
        for (int i = 1; i <= 3; i++) ry[i] = 63;
        run_txn("sample rej");
        fill(5, 7, 1);
        run_txn("exhaust");
        fill_rand();
        occ[0] = 1;
        occ[1] = 1;
        for (int i = 2; i < 16; i++) occ[i] = 0;
        run_txn("third cand");
        fill(12, 3, 1);
        run_txn("counter reset");
        for (int t = 0; t < 30; t++) begin
            fill_rand();
            run_txn("random");
        end

        // clear wins over a simultaneous request
        fill(5, 7, 0);
        run_txn("pre clear");
        @(posedge clk); #1;
        clear = 1;
        place_req = 1;
        @(posedge clk); #1;
        clear = 0;
        place_req = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("clear+req busy", busy, 0);
        chk("clear+req valid", food_valid, 0);
        m_fv = 0;

        // clear while waiting for the occupancy answer
        qidx = 0;
        fill(20, 20, 0);
        @(posedge clk); #1;
        place_req = 1;
        rnd_x = 20;
        rnd_y = 20;
        @(posedge clk); #1;
        base = cyc;
        place_req = 0;
        sb.push_back('{0, 1, 20, 20});
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        repeat (4) @(posedge clk);
        #1;
        post_check("clear in wait");

        // reset while the query is outstanding
        qidx = 0;
        @(posedge clk); #1;
        place_req = 1;
        @(posedge clk); #1;
        place_req = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #2;
        chk("rst mid query_valid", query_valid, 0);
        chk("rst mid busy", busy, 0);
        chk("rst mid food_x", food_x, 0);
        chk("rst mid query_x", query_x, 0);
        m_fx = 0;
        m_fy = 0;
        m_fv = 0;
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        post_check("after rst");
        fill(33, 29, 0);
        run_txn("after rst place");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
